kv_lookup_engine: RTL and testbench
===================================

// Module: kv_lookup_engine
// PURPOSE
//  Key-value table responder at the far end of the encap key interface (in_key/in_flag/in_valid -> out_valid/out_flag).
//  Receives one request per cycle from the Ethernet encap, runs GET/SET/DEL against a direct-mapped key table
//  and returns a result flag at fixed latency. Sits in the clk156 domain beside the encap. Values are not stored.
// PARAMETERS
//  KEY_SIZE    96  key width in bits
//  INDEX_BITS  8   table index width; DEPTH = 2**INDEX_BITS entries, each {valid, key}
// PORTS
//  clk156     in   1             156.25 MHz Ethernet core clock
//  eth_rst    in   1             synchronous, active-high reset
//  in_key     in   KEY_SIZE      request key
//  in_flag    in   4             opcode: 4'b0001 GET, 4'b0010 SET, 4'b0100 DEL; any other value is illegal
//  in_valid   in   1             request strobe, one request per cycle, no backpressure
//  out_valid  out  1             response strobe
//  out_flag   out  4             [0] HIT, [1] WRITTEN, [2] EVICT, [3] ERR
//  init_done  out  1             table clear sweep complete
//  occupancy  out  INDEX_BITS+1  number of valid entries
// BEHAVIOUR
//  Reset: out_valid=0, out_flag=0, init_done=0, occupancy=0. In-flight requests are dropped; no response is issued for them.
//  Init sweep: starts the first cycle eth_rst is low. A counter clears entry 0..DEPTH-1, one per cycle.
//   init_done rises the cycle after entry DEPTH-1 is cleared.
//   A request sampled while init_done=0 returns out_flag=4'b1000 with no table change.
//   eth_rst during the sweep restarts it from entry 0.
//  Index: key zero-extended to a multiple of INDEX_BITS; XOR of all INDEX_BITS-wide chunks.
//   Default INDEX_BITS=8: XOR of the 12 key bytes.
//  Pipeline, 2 stages, fully pipelined:
//   S0: register the request, compute the index, issue a synchronous table read.
//   S1: compare keys, write the table, drive the response.
//   A request sampled at edge N gives out_valid=1 for exactly one cycle after edge N+2.
//  Hazard: if S0 reads the index S1 is writing in the same cycle, S1's new entry is forwarded to S0.
//   Back-to-back same-index requests must see the prior result.
//  HIT = entry valid and stored key == in_key.
//  GET: hit -> 4'b0001; miss -> 4'b0000; table unchanged.
//  SET: writes {1, key}.
//   Same key already present -> 4'b0011.
//   Empty slot -> 4'b0010, occupancy+1.
//   Different valid key present -> 4'b0110 (overwrite); occupancy unchanged.
//  DEL: hit -> 4'b0001, valid cleared, occupancy-1; miss -> 4'b0000; table unchanged.
//  Illegal in_flag (0000, 1000, or multi-bit): 4'b1000, no table change.
//  occupancy never exceeds DEPTH and never underflows; it updates on the same edge as the table write.
//  in_valid=0: no response; out_flag returns to 4'b0000 when out_valid=0.
// TESTING
//  1. Reset, then GET key 96'h1 at cycle 5 -> out_flag 1000 two cycles later.
//     After init_done (DEPTH+1 cycles), GET 96'h1 -> 0000.
//  2. SET 96'h1, then GET 96'h1 on the next cycle (forwarding path) -> 0010 then 0001; occupancy=1.
//  3. SET 96'h100 (same index as 96'h1) -> 0110, occupancy=1. Then GET 96'h1 -> 0000 and GET 96'h100 -> 0001.
//  4. DEL 96'h100 -> 0001, occupancy=0. Repeat DEL 96'h100 -> 0000, occupancy stays 0.
//  5. in_flag 4'b0011 with key 96'h5 -> 1000. Following GET 96'h5 -> 0000; occupancy unchanged.
//  6. SET 96'h7, then assert eth_rst for 1 cycle while a GET is in S0.
//     Required: no out_valid for that GET, occupancy=0, init re-sweep, GET 96'h7 after init_done -> 0000.
//  7. Stream 256 back-to-back SETs with distinct indices -> 256 responses at 2-cycle latency; occupancy=256.
//     One more SET to a new key -> 0110; occupancy stays 256.

Source files
------------

// File: rtl/kv_lookup_engine_if.sv
// Request/response bundle between the Ethernet encap and the key table.
// The encap is the master; the lookup engine is the slave.
interface kv_lookup_engine_if #(
    parameter int KEY_SIZE   = 96,
    parameter int INDEX_BITS = 8
);
    logic [KEY_SIZE-1:0]   in_key;
    logic [3:0]            in_flag;
    logic                  in_valid;
    logic                  out_valid;
    logic [3:0]            out_flag;
    logic                  init_done;
    logic [INDEX_BITS:0]   occupancy;

    modport master (
        output in_key, in_flag, in_valid,
        input  out_valid, out_flag, init_done, occupancy
    );

    modport slave (
        input  in_key, in_flag, in_valid,
        output out_valid, out_flag, init_done, occupancy
    );
endinterface

// File: rtl/kv_lookup_engine.sv
// Direct-mapped key table answering GET/SET/DEL at fixed latency.
// Two-stage pipeline with write-to-read forwarding; table cleared by a sweep.
module kv_lookup_engine #(
    parameter int KEY_SIZE   = 96,
    parameter int INDEX_BITS = 8
) (
    input logic               clk156,
    input logic               eth_rst,
    kv_lookup_engine_if.slave bus
);
    localparam int DEPTH  = 2 ** INDEX_BITS;
    localparam int CHUNKS = (KEY_SIZE + INDEX_BITS - 1) / INDEX_BITS;
    localparam int PAD_W  = CHUNKS * INDEX_BITS;

    localparam logic [3:0] F_GET = 4'b0001;
    localparam logic [3:0] F_SET = 4'b0010;
    localparam logic [3:0] F_DEL = 4'b0100;
    localparam logic [3:0] F_ERR = 4'b1000;

    localparam logic [INDEX_BITS:0] OCC_MAX = (INDEX_BITS + 1)'(DEPTH);

    typedef logic [INDEX_BITS-1:0] idx_t;
    typedef logic [KEY_SIZE-1:0]   key_t;

    // XOR-fold of the zero-extended key into one index-wide chunk.
    function automatic idx_t key_index(input key_t k);
        logic [PAD_W-1:0] p;
        idx_t             r;
        p = PAD_W'(k);
        r = '0;
        for (int c = 0; c < CHUNKS; c++) begin
            r = r ^ p[c*INDEX_BITS +: INDEX_BITS];
        end
        return r;
    endfunction

    // Table storage
    logic [DEPTH-1:0] tbl_vld_q;
    key_t             tbl_key_q [DEPTH];

    // Init sweep
    idx_t init_cnt_q;
    logic init_done_q;

    // S0 request registers
    logic       s0_vld_q;
    logic       s0_err_q;
    logic [2:0] s0_op_q;
    key_t       s0_key_q;
    idx_t       s0_idx_q;

    // S1 request registers plus table read data
    logic       s1_vld_q;
    logic       s1_err_q;
    logic [2:0] s1_op_q;
    key_t       s1_key_q;
    idx_t       s1_idx_q;
    logic       s1_rd_vld_q;
    key_t       s1_rd_key_q;

    // Response registers
    logic                out_vld_q;
    logic [3:0]          out_flag_q;
    logic [INDEX_BITS:0] occ_q;

    // S1 combinational results
    logic                hit;
    logic                wr_en;
    logic                wr_vld;
    logic [3:0]          flag_d;
    logic [INDEX_BITS:0] occ_d;
    logic                in_legal;
    logic                fwd;

    assign in_legal = (bus.in_flag == F_GET) ||
                      (bus.in_flag == F_SET) ||
                      (bus.in_flag == F_DEL);

    assign hit = s1_rd_vld_q && (s1_rd_key_q == s1_key_q);
    assign fwd = wr_en && (s1_idx_q == s0_idx_q);

    // Sweep counter walks every entry once after reset, then holds done.
    always_ff @(posedge clk156) begin
        if (eth_rst) begin
            init_cnt_q  <= '0;
            init_done_q <= 1'b0;
        end else if (!init_done_q) begin
            init_cnt_q <= init_cnt_q + 1'b1;
            if (init_cnt_q == idx_t'(DEPTH - 1)) begin
                init_done_q <= 1'b1;
            end
        end
    end

    // Valid bits: cleared by the sweep, otherwise written by S1.
    always_ff @(posedge clk156) begin
        if (!eth_rst) begin
            if (!init_done_q) begin
                tbl_vld_q[init_cnt_q] <= 1'b0;
            end else if (wr_en) begin
                tbl_vld_q[s1_idx_q] <= wr_vld;
            end
        end
    end

    // Key storage, written alongside the valid bit.
    always_ff @(posedge clk156) begin
        if (!eth_rst && wr_en) begin
            tbl_key_q[s1_idx_q] <= s1_key_q;
        end
    end

    // Pipeline strobes; reset drops whatever is in flight.
    always_ff @(posedge clk156) begin
        if (eth_rst) begin
            s0_vld_q <= 1'b0;
            s1_vld_q <= 1'b0;
        end else begin
            s0_vld_q <= bus.in_valid;
            s1_vld_q <= s0_vld_q;
        end
    end

    // Pipeline data: S0 captures and indexes, S1 gets the table read.
    always_ff @(posedge clk156) begin
        s0_key_q <= bus.in_key;
        s0_idx_q <= key_index(bus.in_key);
        s0_op_q  <= bus.in_flag[2:0];
        s0_err_q <= !init_done_q || !in_legal;
        s1_key_q <= s0_key_q;
        s1_idx_q <= s0_idx_q;
        s1_op_q  <= s0_op_q;
        s1_err_q <= s0_err_q;
        if (fwd) begin
            s1_rd_vld_q <= wr_vld;
            s1_rd_key_q <= s1_key_q;
        end else begin
            s1_rd_vld_q <= tbl_vld_q[s0_idx_q];
            s1_rd_key_q <= tbl_key_q[s0_idx_q];
        end
    end

    // S1 decision: response flag, table write and occupancy change.
    always_comb begin
        wr_en  = 1'b0;
        wr_vld = 1'b0;
        flag_d = 4'b0000;
        occ_d  = occ_q;
        if (s1_vld_q) begin
            if (s1_err_q) begin
                flag_d = F_ERR;
            end else begin
                unique case (1'b1)
                    s1_op_q[0]: begin
                        flag_d = {3'b000, hit};
                    end
                    s1_op_q[1]: begin
                        wr_en  = 1'b1;
                        wr_vld = 1'b1;
                        if (hit) begin
                            flag_d = 4'b0011;
                        end else if (!s1_rd_vld_q) begin
                            flag_d = 4'b0010;
                            if (occ_q != OCC_MAX) begin
                                occ_d = occ_q + 1'b1;
                            end
                        end else begin
                            flag_d = 4'b0110;
                        end
                    end
                    s1_op_q[2]: begin
                        if (hit) begin
                            flag_d = 4'b0001;
                            wr_en  = 1'b1;
                            wr_vld = 1'b0;
                            if (occ_q != '0) begin
                                occ_d = occ_q - 1'b1;
                            end
                        end
                    end
                    default: begin
                        flag_d = F_ERR;
                    end
                endcase
            end
        end
    end

    // Registered response and occupancy.
    always_ff @(posedge clk156) begin
        if (eth_rst) begin
            out_vld_q  <= 1'b0;
            out_flag_q <= 4'b0000;
            occ_q      <= '0;
        end else begin
            out_vld_q  <= s1_vld_q;
            out_flag_q <= flag_d;
            occ_q      <= occ_d;
        end
    end

    assign bus.out_valid = out_vld_q;
    assign bus.out_flag  = out_flag_q;
    assign bus.init_done = init_done_q;
    assign bus.occupancy = occ_q;
endmodule

// File: tb/tb_kv_lookup_engine.sv
// Directed bench for kv_lookup_engine.
// Responses are matched against an expected queue stamped with due cycle.
module tb_kv_lookup_engine;
    logic clk156 = 1'b0;
    logic eth_rst;

    always #5 clk156 = ~clk156;

    kv_lookup_engine_if bus ();

    kv_lookup_engine dut (
        .clk156  (clk156),
        .eth_rst (eth_rst),
        .bus     (bus)
    );

    typedef struct {
        logic [3:0] flag;
        int         occ;
        int         due;
    } exp_t;

    typedef struct {
        logic [95:0] key;
        logic [3:0]  flag;
        logic [3:0]  exp_flag;
        int          exp_occ;
    } vec_t;

    exp_t exp_q[$];
    vec_t vt[16];
    int   cyc    = 0;
    int   checks = 0;
    int   fails  = 0;
    int   c0;

    always @(posedge clk156) cyc <= cyc + 1;

    // Response monitor
    always @(negedge clk156) begin
        exp_t e;
        if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
            checks++;
            fails++;
            $display("FAIL missing_resp due=%0d now=%0d", exp_q[0].due, cyc);
            void'(exp_q.pop_front());
        end
        if (bus.out_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL spurious_resp cyc=%0d flag=%b", cyc, bus.out_flag);
            end else begin
                e = exp_q.pop_front();
                if (bus.out_flag !== e.flag || int'(bus.occupancy) != e.occ ||
                    cyc != e.due) begin
                    fails++;
                    $display("FAIL resp cyc=%0d flag=%b occ=%0d required cyc=%0d flag=%b occ=%0d",
                             cyc, bus.out_flag, bus.occupancy, e.due, e.flag, e.occ);
                end
            end
        end else if (eth_rst === 1'b0) begin
            checks++;
            if (bus.out_flag !== 4'b0000) begin
                fails++;
                $display("FAIL idle_flag cyc=%0d actual=%b required=0000", cyc, bus.out_flag);
            end
        end
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", n, act, req);
        end
    endtask

    // Called just after a negedge; request is sampled on the next posedge.
    task automatic send(input logic [95:0] k, input logic [3:0] f,
                        input logic [3:0] ef, input int eo);
        exp_t e;
        bus.in_key   = k;
        bus.in_flag  = f;
        bus.in_valid = 1'b1;
        e.flag = ef;
        e.occ  = eo;
        e.due  = cyc + 3;
        exp_q.push_back(e);
        @(negedge clk156);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_init();
        for (int k = 0; k < 400 && bus.init_done !== 1'b1; k++) begin
            @(negedge clk156);
        end
        chk("init_done_wait", 32'(bus.init_done), 32'd1);
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && exp_q.size() > 0; k++) begin
            @(negedge clk156);
        end
        chk("drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        vt[0]  = '{96'h1,   4'b0001, 4'b0000, 0};
        vt[1]  = '{96'h1,   4'b0010, 4'b0010, 1};
        vt[2]  = '{96'h1,   4'b0001, 4'b0001, 1};
        vt[3]  = '{96'h100, 4'b0010, 4'b0110, 1};
        vt[4]  = '{96'h1,   4'b0001, 4'b0000, 1};
        vt[5]  = '{96'h100, 4'b0001, 4'b0001, 1};
        vt[6]  = '{96'h100, 4'b0100, 4'b0001, 0};
        vt[7]  = '{96'h100, 4'b0100, 4'b0000, 0};
        vt[8]  = '{96'h5,   4'b0011, 4'b1000, 0};
        vt[9]  = '{96'h5,   4'b0001, 4'b0000, 0};
        vt[10] = '{96'h5,   4'b0000, 4'b1000, 0};
        vt[11] = '{96'h5,   4'b1000, 4'b1000, 0};
        vt[12] = '{96'h5,   4'b0010, 4'b0010, 1};
        vt[13] = '{96'h5,   4'b0010, 4'b0011, 1};
        vt[14] = '{96'h5,   4'b0100, 4'b0001, 0};
        vt[15] = '{96'h5,   4'b0001, 4'b0000, 0};

        bus.in_key   = '0;
        bus.in_flag  = '0;
        bus.in_valid = 1'b0;
        eth_rst      = 1'b1;
        repeat (3) @(negedge clk156);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_flag", 32'(bus.out_flag), 32'd0);
        chk("rst_init_done", 32'(bus.init_done), 32'd0);
        chk("rst_occupancy", 32'(bus.occupancy), 32'd0);

        // Request during the sweep is rejected
        eth_rst = 1'b0;
        c0 = cyc;
        while (cyc < c0 + 4) @(negedge clk156);
        send(96'h1, 4'b0001, 4'b1000, 0);
        while (cyc < c0 + 255) @(negedge clk156);
        chk("init_done_early", 32'(bus.init_done), 32'd0);
        @(negedge clk156);
        chk("init_done_edge", 32'(bus.init_done), 32'd1);
        drain();

        // Back-to-back table vectors, exercising forwarding
        for (int i = 0; i < 16; i++) begin
            send(vt[i].key, vt[i].flag, vt[i].exp_flag, vt[i].exp_occ);
        end
        drain();
        chk("occ_after_vectors", 32'(bus.occupancy), 32'd0);

        // Reset while a GET sits in S0
        send(96'h7, 4'b0010, 4'b0010, 1);
        drain();
        bus.in_key   = 96'h7;
        bus.in_flag  = 4'b0001;
        bus.in_valid = 1'b1;
        @(negedge clk156);
        bus.in_valid = 1'b0;
        eth_rst = 1'b1;
        @(negedge clk156);
        eth_rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("rst_drop_valid", 32'(bus.out_valid), 32'd0);
            @(negedge clk156);
        end
        chk("rst2_occupancy", 32'(bus.occupancy), 32'd0);
        chk("rst2_init_done", 32'(bus.init_done), 32'd0);
        wait_init();
        send(96'h7, 4'b0001, 4'b0000, 0);
        drain();

        // Fill every slot, then overwrite one
        for (int i = 0; i < 256; i++) begin
            send(96'(i), 4'b0010, 4'b0010, i + 1);
        end
        send(96'h100, 4'b0010, 4'b0110, 256);
        drain();
        chk("occ_full", 32'(bus.occupancy), 32'd256);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
